lsu_mem_port: RTL and testbench

- Load/store unit between the pipeline MEM stage and the word-addressed data `memory` block.
- Converts byte-addressed byte/half/word loads and stores into that block's registered-input word accesses.
- Loads are sign/zero-extended. Sub-word stores use read-modify-write, because the memory only writes whole words.
- Single outstanding request; valid/ready request side, single-cycle response pulse.

---
 rtl/lsu_mem_port.sv | 160 ++++++++++++++++
 tb/tb_lsu_mem_port.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit bridging byte-addressed MEM-stage requests to a word-addressed, registered-input memory.
// Optional LSU_ALIGN_CHECK_EN: reject misaligned/out-of-range requests instead of force-aligning them.
module lsu_mem_port #(
    parameter int MEM_WORDS = 128,
    parameter int WIDTH     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic             mem_w_enable,
    output logic             mem_r_enable,
    output logic [31:0]      mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHK     = 3'd1;
    localparam logic [2:0] S_LD_REQ  = 3'd2;
    localparam logic [2:0] S_LD_DATA = 3'd3;
    localparam logic [2:0] S_RMW_RD  = 3'd4;
    localparam logic [2:0] S_RMW_MRG = 3'd5;
    localparam logic [2:0] S_ST_WR   = 3'd6;
    localparam logic [2:0] S_RESP    = 3'd7;

    logic [2:0]  state;
    logic [31:0] a_addr;
    logic [1:0]  a_size;
    logic        a_we;
    logic        a_uns;
    logic [31:0] a_wdata;

    logic [1:0]  size_eff;
    logic [29:0] word_idx;
    logic        req_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;
    logic [31:0] merge_word;

    assign req_ready = (state == S_IDLE) && !rst;

`ifdef LSU_ALIGN_CHECK_EN
    assign size_eff = a_size;
    assign word_idx = a_addr[31:2];
    assign req_err  = (a_size == 2'b11)
                   || ((a_size == 2'b01) && a_addr[0])
                   || ((a_size == 2'b10) && (a_addr[1:0] != 2'b00))
                   || (a_addr[31:2] >= 30'(MEM_WORDS));
`else
    // Without checking, size 11 behaves as a word and the index wraps within the memory.
    assign size_eff = (a_size == 2'b11) ? 2'b10 : a_size;
    assign word_idx = a_addr[31:2] & 30'(MEM_WORDS - 1);
    assign req_err  = 1'b0;
`endif

    assign lane_b = mem_rdata[{a_addr[1:0], 3'b000} +: 8];
    assign lane_h = mem_rdata[{a_addr[1], 4'b0000} +: 16];

    always_comb begin
        load_data  = mem_rdata;
        merge_word = mem_rdata;
        case (size_eff)
            2'b00: begin
                load_data = a_uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
                merge_word[{a_addr[1:0], 3'b000} +: 8] = a_wdata[7:0];
            end
            2'b01: begin
                load_data = a_uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
                merge_word[{a_addr[1], 4'b0000} +: 16] = a_wdata[15:0];
            end
            default: begin
                load_data  = mem_rdata;
                merge_word = mem_rdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid && !rst) begin
            a_addr  <= req_addr;
            a_size  <= req_size;
            a_we    <= req_we;
            a_uns   <= req_unsigned;
            a_wdata <= req_wdata;
        end
    end

    // Outputs are set on entry to the state that owns them, so they are high exactly while in it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            mem_w_enable <= 1'b0;
            mem_r_enable <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            mem_w_enable <= 1'b0;
            mem_r_enable <= 1'b0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
            case (state)
                S_IDLE: begin
                    if (req_valid) state <= S_CHK;
                end
                S_CHK: begin
                    if (req_err) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else if (!a_we) begin
                        state        <= S_LD_REQ;
                        mem_r_enable <= 1'b1;
                        mem_addr     <= {2'b00, word_idx};
                    end else if (size_eff == 2'b10) begin
                        state        <= S_ST_WR;
                        mem_w_enable <= 1'b1;
                        mem_addr     <= {2'b00, word_idx};
                        mem_wdata    <= a_wdata;
                    end else begin
                        state        <= S_RMW_RD;
                        mem_r_enable <= 1'b1;
                        mem_addr     <= {2'b00, word_idx};
                    end
                end
                S_LD_REQ:  state <= S_LD_DATA;
                S_LD_DATA: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_data;
                end
                S_RMW_RD:  state <= S_RMW_MRG;
                S_RMW_MRG: begin
                    state        <= S_ST_WR;
                    mem_w_enable <= 1'b1;
                    mem_wdata    <= merge_word;
                end
                S_ST_WR: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed cases plus random traffic against a word-array reference model.
module tb_lsu_mem_port;

    localparam int MEM_WORDS = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_w_enable;
    logic        mem_r_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_array [MEM_WORDS];
    logic [31:0] ref_mem   [MEM_WORDS];

    logic [31:0] op_rdata;
    logic        op_err;
    int          op_lat;
    logic        op_saw_r;
    logic        op_saw_w;
    int          op_first_r;
    int          op_first_w;
    logic        op_ready_bad;
    logic [31:0] op_addr_seen;

    lsu_mem_port #(.MEM_WORDS(MEM_WORDS), .WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_w_enable(mem_w_enable), .mem_r_enable(mem_r_enable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory with registered inputs: read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (mem_w_enable) mem_array[mem_addr[6:0]] <= mem_wdata;
        if (mem_r_enable) mem_rdata <= mem_array[mem_addr[6:0]];
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int wait_cyc;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        op_lat = 0; op_saw_r = 0; op_saw_w = 0; op_first_r = 0; op_first_w = 0;
        op_ready_bad = 0; op_addr_seen = '0; op_rdata = '0; op_err = 0;
        if (!req_ready) begin
            checkOutput("accept_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_r_enable && !op_saw_r) begin
                op_saw_r = 1; op_first_r = c; op_addr_seen = mem_addr;
            end
            if (mem_w_enable && !op_saw_w) begin
                op_saw_w = 1; op_first_w = c;
                if (!op_saw_r) op_addr_seen = mem_addr;
            end
            if (req_ready) op_ready_bad = 1;
            if (resp_valid) begin
                op_lat = c; op_rdata = resp_rdata; op_err = resp_err;
                break;
            end
        end
        if (op_lat == 0) checkOutput("resp_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic isErr(input logic [1:0] size, input logic [31:0] addr);
`ifdef LSU_ALIGN_CHECK_EN
        return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0)
            || (addr / 4 >= MEM_WORDS);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int idxOf(input logic [31:0] addr);
        return int'((addr / 4) % MEM_WORDS);
    endfunction

    task automatic checkOp(input string tag, input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        logic        e_err;
        logic [1:0]  sz;
        logic [31:0] w, v, e_rdata;
        int          e_lat, idx, sh;
        e_err = isErr(size, addr);
        sz = (size == 3) ? 2'd2 : size;
        idx = idxOf(addr);
        w = ref_mem[idx];
        e_rdata = 0;
        if (e_err) e_lat = 2;
        else if (!we) e_lat = 4;
        else if (sz == 2) e_lat = 3;
        else e_lat = 5;
        if (!e_err && !we) begin
            if (sz == 0) begin
                sh = 8 * int'(addr % 4);
                v = (w >> sh) % 256;
                if (!uns && v >= 128) v = v - 256;
            end else if (sz == 1) begin
                sh = 16 * int'((addr / 2) % 2);
                v = (w >> sh) % 65536;
                if (!uns && v >= 32768) v = v - 65536;
            end else v = w;
            e_rdata = v;
        end
        applyStimulus(we, size, uns, addr, wdata);
        checkOutput({tag, "_lat"}, op_lat, e_lat);
        checkOutput({tag, "_err"}, {31'b0, op_err}, {31'b0, e_err});
        checkOutput({tag, "_rdata"}, op_rdata, e_rdata);
        checkOutput({tag, "_ready_busy"}, {31'b0, op_ready_bad}, 32'd0);
        if (e_err) checkOutput({tag, "_no_enable"}, {30'b0, op_saw_r, op_saw_w}, 32'd0);
        else checkOutput({tag, "_addr"}, op_addr_seen, idx);
        if (!e_err && we && sz != 2)
            checkOutput({tag, "_rmw_order"}, {31'b0, op_saw_r && op_saw_w && (op_first_r < op_first_w)}, 32'd1);
        if (!e_err && we) begin
            if (sz == 0) begin
                sh = 8 * int'(addr % 4);
                ref_mem[idx] = (w & ~(32'hFF << sh)) | ((wdata % 256) << sh);
            end else if (sz == 1) begin
                sh = 16 * int'((addr / 2) % 2);
                ref_mem[idx] = (w & ~(32'hFFFF << sh)) | ((wdata % 65536) << sh);
            end else ref_mem[idx] = wdata;
        end
    endtask

    initial begin
        int accepts [$];
        int resp_cnt;
        logic [1:0] r_size;
        logic [31:0] r_addr;

        for (int i = 0; i < MEM_WORDS; i++) begin
            mem_array[i] = '0;
            ref_mem[i]   = '0;
        end
        rst = 1'b1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("rst_outs", {28'b0, resp_valid, resp_err, mem_w_enable, mem_r_enable}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;

        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_hold", {29'b0, req_ready, mem_w_enable, mem_r_enable}, 32'd4);
        end

        checkOp("st_w", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        checkOp("ld_w", 0, 2'd2, 0, 32'h10, 32'h0);
        checkOutput("tp_deadbeef", op_rdata, 32'hDEADBEEF);
        checkOutput("tp_mem_addr4", op_addr_seen, 32'd4);
        checkOp("st_b", 1, 2'd0, 0, 32'h11, 32'h00000055);
        checkOp("ld_w2", 0, 2'd2, 0, 32'h10, 32'h0);
        checkOutput("tp_dead55ef", op_rdata, 32'hDEAD55EF);
        checkOp("ld_bs", 0, 2'd0, 0, 32'h13, 32'h0);
        checkOutput("tp_bs", op_rdata, 32'hFFFFFFDE);
        checkOp("ld_bu", 0, 2'd0, 1, 32'h13, 32'h0);
        checkOutput("tp_bu", op_rdata, 32'h000000DE);
        checkOp("ld_hs", 0, 2'd1, 0, 32'h12, 32'h0);
        checkOutput("tp_hs", op_rdata, 32'hFFFFDEAD);
        checkOp("ld_h_mis", 0, 2'd1, 0, 32'h11, 32'h0);
        checkOp("ld_w_far", 0, 2'd2, 0, 32'h200, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
        checkOutput("tp_far_err", {31'b0, op_err}, 32'd1);
`else
        checkOutput("tp_far_wrap", op_addr_seen, 32'd0);
`endif

        // Reset lands while the byte store is merging; the write must never happen.
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'd0; req_unsigned = 0;
        req_addr = 32'h11; req_wdata = 32'hAA;
        @(posedge clk);
        #1 req_valid = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_outs", {30'b0, resp_valid, mem_w_enable}, 32'd0);
        checkOutput("rstmid_ready_low", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_idle", {31'b0, req_ready}, 32'd1);
        resp_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) resp_cnt++;
        end
        checkOutput("rstmid_no_resp", resp_cnt, 32'd0);
        checkOp("rstmid_ld", 0, 2'd2, 0, 32'h10, 32'h0);
        checkOutput("rstmid_unchanged", op_rdata, 32'hDEAD55EF);

        // Back-to-back loads with req_valid held high.
        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h10;
        resp_cnt = 0;
        for (int c = 0; c < 22; c++) begin
            if (req_ready) accepts.push_back(c);
            if (resp_valid) begin
                resp_cnt++;
                checkOutput("b2b_rdata", resp_rdata, ref_mem[4]);
            end
            @(negedge clk);
        end
        req_valid = 0;
        repeat (8) @(negedge clk);
        checkOutput("b2b_accepts", accepts.size(), 32'd5);
        checkOutput("b2b_resps", resp_cnt, 32'd4);
        for (int i = 1; i < accepts.size(); i++)
            checkOutput("b2b_spacing", accepts[i] - accepts[i-1], 32'd5);

        for (int n = 0; n < 40; n++) begin
            r_size = 2'($urandom_range(0, 3));
            r_addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, 63));
            checkOp("rnd", 1'($urandom_range(0, 1)), r_size, 1'($urandom_range(0, 1)), r_addr, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
